// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: scheduler states and
// register-file addressing.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_loaduse_detect.sv
// Load-use comparator: a load in ID/EX whose destination is read by the
// instruction in IF/ID. Writes to the zero register never create a hazard.
module pipe_loaduse_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                  mem_read_i,
    input  logic [REG_ADDR_W-1:0] idex_rt_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs_i,
    input  logic [REG_ADDR_W-1:0] ifid_rt_i,
    output logic                  lu_o
);

    // Hazard when the load target matches either source field of IF/ID.
    always_comb begin
        lu_o = mem_read_i && (idex_rt_i != ZERO_REG) &&
               ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use bubbles, branch
// flushes, whole-pipeline freeze on data-cache misses, cache watchdog and a
// saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TMO_W       = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  IDEX_MemRead_i,
    input  logic [REG_ADDR_W-1:0] IDEX_RTaddr_i,
    input  logic [REG_ADDR_W-1:0] IFID_RSaddr_i,
    input  logic [REG_ADDR_W-1:0] IFID_RTaddr_i,
    input  logic                  branch_taken_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ack_i,
    output logic                  mem_req_o,
    output logic                  pc_we_o,
    output logic                  ifid_we_o,
    output logic                  idex_we_o,
    output logic                  exmem_we_o,
    output logic                  memwb_we_o,
    output logic                  ifid_flush_o,
    output logic                  idex_bubble_o,
    output logic                  mem_stall_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic                  err_o
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_e           state_q;
    state_e           state_d;
    logic [TMO_W-1:0] tmo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             lu;
    logic             memstall;
    logic             cnt_en;

    pipe_loaduse_detect u_lu (
        .mem_read_i (IDEX_MemRead_i),
        .idex_rt_i  (IDEX_RTaddr_i),
        .ifid_rs_i  (IFID_RSaddr_i),
        .ifid_rt_i  (IFID_RTaddr_i),
        .lu_o       (lu)
    );

    // Cache freeze: a miss in RUN, or any MEM_WAIT cycle without the ack.
    always_comb begin
        memstall = ((state_q == RUN) && mem_req_i && !mem_ack_i) ||
                   ((state_q == MEM_WAIT) && !mem_ack_i);
        cnt_en   = memstall || (lu && (state_q != ERR));
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ERR is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i) begin
                    state_d = RUN;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ERR;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase
    end

    // Watchdog: counts consecutive MEM_WAIT cycles, zero everywhere else.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tmo_q <= '0;
        end else if ((state_q == MEM_WAIT) && (state_d == MEM_WAIT)) begin
            tmo_q <= tmo_q + 1'b1;
        end else begin
            tmo_q <= '0;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (cnt_en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Stage controls by priority ERR > memstall > lu > branch > normal;
    // reset forces every control low without waiting for a clock.
    always_comb begin
        pc_we_o       = 1'b0;
        ifid_we_o     = 1'b0;
        idex_we_o     = 1'b0;
        exmem_we_o    = 1'b0;
        memwb_we_o    = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        mem_stall_o   = 1'b0;
        mem_req_o     = 1'b0;
        if (rst_i && (state_q != ERR)) begin
            mem_req_o = mem_req_i;
            if (memstall) begin
                mem_stall_o = 1'b1;
            end else begin
                idex_we_o  = 1'b1;
                exmem_we_o = 1'b1;
                memwb_we_o = 1'b1;
                if (lu) begin
                    idex_bubble_o = 1'b1;
                end else begin
                    pc_we_o      = 1'b1;
                    ifid_we_o    = 1'b1;
                    ifid_flush_o = branch_taken_i;
                end
            end
        end
    end

    assign err_o       = (state_q == ERR);
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: each cycle's stimulus carries its
// hand-computed expected controls into a queue; a monitor checks them.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [6:0] ctrl;   // {pc,ifid,idex,exmem,memwb we, flush, bubble}
        logic       mreq;
        logic       mstall;
        logic       err;
        logic [2:0] cnt;
    } exp_t;

    localparam logic [6:0] C_NORM = 7'b11111_00;
    localparam logic [6:0] C_BR   = 7'b11111_10;
    localparam logic [6:0] C_LU   = 7'b00111_01;
    localparam logic [6:0] C_OFF  = 7'b00000_00;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       IDEX_MemRead_i = 1'b0;
    logic [4:0] IDEX_RTaddr_i = '0;
    logic [4:0] IFID_RSaddr_i = '0;
    logic [4:0] IFID_RTaddr_i = '0;
    logic       branch_taken_i = 1'b0;
    logic       mem_req_i = 1'b0;
    logic       mem_ack_i = 1'b0;
    logic       mem_req_o;
    logic       pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, memwb_we_o;
    logic       ifid_flush_o, idex_bubble_o, mem_stall_o, err_o;
    logic [2:0] stall_cnt_o;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (3),
        .TMO_W       (8)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .IDEX_MemRead_i (IDEX_MemRead_i),
        .IDEX_RTaddr_i  (IDEX_RTaddr_i),
        .IFID_RSaddr_i  (IFID_RSaddr_i),
        .IFID_RTaddr_i  (IFID_RTaddr_i),
        .branch_taken_i (branch_taken_i),
        .mem_req_i      (mem_req_i),
        .mem_ack_i      (mem_ack_i),
        .mem_req_o      (mem_req_o),
        .pc_we_o        (pc_we_o),
        .ifid_we_o      (ifid_we_o),
        .idex_we_o      (idex_we_o),
        .exmem_we_o     (exmem_we_o),
        .memwb_we_o     (memwb_we_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .mem_stall_o    (mem_stall_o),
        .stall_cnt_o    (stall_cnt_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int step_no,
                         input logic [6:0] act, input logic [6:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s step %0d: got %b expected %b", name, step_no, act, req);
        end
    endtask

    // Apply one cycle of stimulus just after the rising edge and queue what
    // the outputs must look like for the rest of that cycle.
    task automatic step(input logic rst, input logic mr, input logic [4:0] rt,
                        input logic [4:0] rs, input logic [4:0] rtf,
                        input logic br, input logic req, input logic ack,
                        input logic [6:0] c, input logic mq, input logic ms,
                        input logic er, input logic [2:0] cnt);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i          = rst;
        IDEX_MemRead_i = mr;
        IDEX_RTaddr_i  = rt;
        IFID_RSaddr_i  = rs;
        IFID_RTaddr_i  = rtf;
        branch_taken_i = br;
        mem_req_i      = req;
        mem_ack_i      = ack;
        e.ctrl   = c;
        e.mreq   = mq;
        e.mstall = ms;
        e.err    = er;
        e.cnt    = cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: mid-cycle, compare the live outputs against the oldest entry.
    initial begin
        exp_t e;
        int   n = 0;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n++;
                check("ctrl", n, {pc_we_o, ifid_we_o, idex_we_o, exmem_we_o,
                                  memwb_we_o, ifid_flush_o, idex_bubble_o}, e.ctrl);
                check("mem_req", n, {6'b0, mem_req_o}, {6'b0, e.mreq});
                check("mem_stall", n, {6'b0, mem_stall_o}, {6'b0, e.mstall});
                check("err", n, {6'b0, err_o}, {6'b0, e.err});
                check("stall_cnt", n, {4'b0, stall_cnt_o}, {4'b0, e.cnt});
            end
        end
    end

    initial begin
        int drain = 0;
        //    rst mr rt    rs    rtf   br req ack  ctrl   mq ms er cnt
        // reset held low: everything forced off even with hazards present
        step(0, 1, 5'd8, 5'd8, 5'd0, 1, 1, 0, C_OFF, 0, 0, 0, 3'd0);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NORM, 0, 0, 0, 3'd0);
        // load-use on rs, then on rt field; zero register never stalls
        step(1, 1, 5'd8, 5'd8, 5'd1, 0, 0, 0, C_LU,   0, 0, 0, 3'd0);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NORM, 0, 0, 0, 3'd1);
        step(1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NORM, 0, 0, 0, 3'd1);
        step(1, 1, 5'd5, 5'd3, 5'd5, 0, 0, 0, C_LU,   0, 0, 0, 3'd1);
        // branch alone flushes; branch under load-use bubbles instead
        step(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, C_BR,   0, 0, 0, 3'd2);
        step(1, 1, 5'd8, 5'd8, 5'd0, 1, 0, 0, C_LU,   0, 0, 0, 3'd2);
        step(1, 0, 5'd8, 5'd8, 5'd0, 0, 0, 0, C_NORM, 0, 0, 0, 3'd3);
        // same-cycle ack: no stall
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, C_NORM, 1, 0, 0, 3'd3);
        // miss: three frozen cycles (lu suppressed), released on ack
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_OFF,  1, 1, 0, 3'd3);
        step(1, 1, 5'd8, 5'd8, 5'd0, 1, 1, 0, C_OFF,  1, 1, 0, 3'd4);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_OFF,  1, 1, 0, 3'd5);
        step(1, 0, 5'd0, 5'd0, 5'd0, 1, 1, 1, C_BR,   1, 0, 0, 3'd6);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NORM, 0, 0, 0, 3'd6);
        // counter saturates at 7
        step(1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0, C_LU,   0, 0, 0, 3'd6);
        step(1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0, C_LU,   0, 0, 0, 3'd7);
        step(1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0, C_LU,   0, 0, 0, 3'd7);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NORM, 0, 0, 0, 3'd7);
        // reset clears the counter; request dropping in MEM_WAIT keeps waiting
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_OFF,  0, 0, 0, 3'd0);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_OFF,  1, 1, 0, 3'd0);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_OFF,  0, 1, 0, 3'd1);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, C_NORM, 0, 0, 0, 3'd2);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NORM, 0, 0, 0, 3'd2);
        // timeout: RUN miss + four MEM_WAIT cycles, then sticky ERR
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_OFF,  1, 1, 0, 3'd2);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_OFF,  1, 1, 0, 3'd3);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_OFF,  1, 1, 0, 3'd4);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_OFF,  1, 1, 0, 3'd5);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_OFF,  1, 1, 0, 3'd6);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_OFF,  0, 0, 1, 3'd7);
        step(1, 0, 5'd0, 5'd0, 5'd0, 1, 1, 1, C_OFF,  0, 0, 1, 3'd7);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_OFF,  0, 0, 1, 3'd7);
        // only reset leaves ERR
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_OFF,  0, 0, 0, 3'd0);
        // async reset in MEM_WAIT abandons the access
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_OFF,  1, 1, 0, 3'd0);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_OFF,  1, 1, 0, 3'd1);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_OFF,  0, 0, 0, 3'd0);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NORM, 0, 0, 0, 3'd0);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, C_NORM, 1, 0, 0, 3'd0);

        while (exp_q.size() != 0 && drain < 20) begin
            @(posedge clk_i);
            drain++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
